// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative radix-2 restoring 32-bit divider (DIV / DIVU) that
//             returns {remainder, quotient} with a one-cycle result strobe.
//  Revision : 1.0  initial release
// ============================================================================
module div_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [7:0] DIV_OP  = 8'b0001_1010,
    parameter logic [7:0] DIVU_OP = 8'b0001_1011
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [7:0]         alucontrol,
    input  logic               annul,
    output logic               busy,
    output logic               result_ok,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH);

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               busy_q, busy_d;
    logic               ok_q, ok_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               w_is_div;
    logic               w_is_divu;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;

    assign w_is_div  = (alucontrol == DIV_OP);
    assign w_is_divu = (alucontrol == DIVU_OP);
    assign w_accept  = (w_is_div || w_is_divu) && !annul;

    assign w_a_mag = (w_is_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_b_mag = (w_is_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Partial remainder is always below the divisor, so a 33-bit trial
    // difference is wide enough for its MSB to act as the borrow.
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, dvs_q};

    assign w_rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
    assign w_quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cnt_d   = '0;
                    dvs_d   = w_b_mag;
                    state_d = S_CALC;
                    // A zero divisor finalises on the next edge: the raw
                    // dividend becomes the remainder and the quotient is all ones.
                    if (b == '0) begin
                        rem_d  = a;
                        quo_d  = '1;
                        qneg_d = 1'b0;
                        rneg_d = 1'b0;
                    end else begin
                        rem_d  = '0;
                        quo_d  = w_a_mag;
                        qneg_d = w_is_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d = w_is_div && a[WIDTH-1];
                    end
                end
            end
            S_CALC: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_ITER || dvs_q == '0) begin
                    result_d = {w_rem_fix, w_quo_fix};
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (!w_trial[WIDTH]) begin
                        rem_d = w_trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = w_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        ok_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            ok_q     <= ok_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign result_ok = ok_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Directed plus randomized self-checking bench for div_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [7:0] OP_NOP  = 8'h00;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  alucontrol;
    logic        annul;
    logic        busy;
    logic        result_ok;
    logic [63:0] result;

    int          passed = 0;
    int          total  = 0;
    logic [63:0] last_exp;

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .annul      (annul),
        .busy       (busy),
        .result_ok  (result_ok),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Truncating integer division on 64-bit values; HI = remainder, LO = quotient.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic wait_result(output int n);
        n = 0;
        while (!result_ok && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y, input string tag);
        int          n;
        logic [63:0] exp;
        exp = ref_div(x, y, op == OP_DIV);
        @(negedge clk);
        alucontrol = op; a = x; b = y;
        @(posedge clk); #1;
        alucontrol = OP_NOP; a = $urandom; b = $urandom;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        wait_result(n);
        check({tag, " latency"}, 64'(n), (y == 32'd0) ? 64'd1 : 64'd33);
        check({tag, " result"}, result, exp);
        check({tag, " busy_low_at_result"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " strobe_one_cycle"}, 64'(result_ok), 64'd0);
        last_exp = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [7:0]  op;
        logic [31:0] x, y;

        resetn = 1'b0; annul = 1'b0; alucontrol = OP_NOP; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset result_ok", 64'(result_ok), 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk); resetn = 1'b1;

        run_op(OP_DIVU, 32'd100,        32'd7,          "divu_100_7");
        check("divu_100_7 const", last_exp, {32'd2, 32'd14});
        run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          "div_m7_2");
        run_op(OP_DIVU, 32'hFFFF_FFF9,  32'd2,          "divu_m7_2");
        run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  "div_overflow");
        check("div_overflow const", last_exp, {32'h0, 32'h8000_0000});
        run_op(OP_DIVU, 32'hFFFF_FFFE,  32'd4,          "divu_big_4");
        run_op(OP_DIVU, 32'h0000_1234,  32'd0,          "divu_by_zero");
        run_op(OP_DIV,  32'h8000_0005,  32'd0,          "div_by_zero");
        run_op(OP_DIV,  32'd7,          32'hFFFF_FFFE,  "div_7_m2");

        for (int i = 0; i < 16; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            x  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 50));
                2:       y = -32'($urandom_range(1, 50));
                default: y = 32'($urandom);
            endcase
            run_op(op, x, y, "random");
        end

        // Flush an in-flight DIVU at E10 while DIV is already queued.
        @(negedge clk);
        alucontrol = OP_DIVU; a = 32'd999; b = 32'd5;
        @(posedge clk); #1;
        check("annul busy_after_accept", 64'(busy), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; alucontrol = OP_DIV; a = 32'hFFFF_F000; b = 32'd12;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul busy_dropped", 64'(busy), 64'd0);
        check("annul no_strobe", 64'(result_ok), 64'd0);
        check("annul result_kept", result, last_exp);
        @(posedge clk); #1;
        alucontrol = OP_NOP;
        check("annul next_accept", 64'(busy), 64'd1);
        wait_result(n);
        check("annul next latency", 64'(n), 64'd33);
        check("annul next result", result, ref_div(32'hFFFF_F000, 32'd12, 1'b1));

        // DIV held across completion: the next op is taken as soon as allowed.
        @(posedge clk); #1;
        @(negedge clk);
        alucontrol = OP_DIV; a = 32'h7654_3210; b = 32'hFFFF_FF00;
        @(posedge clk); #1;
        a = 32'hDEAD_BEEF; b = 32'd37;
        wait_result(n);
        check("b2b first latency", 64'(n), 64'd33);
        check("b2b first result", result, ref_div(32'h7654_3210, 32'hFFFF_FF00, 1'b1));
        n = 0;
        while (!busy && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        alucontrol = OP_NOP;
        check("b2b second accepted", 64'(busy), 64'd1);
        wait_result(n);
        check("b2b second latency", 64'(n), 64'd33);
        check("b2b second result", result, ref_div(32'hDEAD_BEEF, 32'd37, 1'b1));

        // Asynchronous reset between edges while in CALC.
        @(posedge clk); #1;
        @(negedge clk);
        alucontrol = OP_DIVU; a = 32'hCAFE_F00D; b = 32'd19;
        @(posedge clk); #1;
        alucontrol = OP_NOP;
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("async_reset busy", 64'(busy), 64'd0);
        check("async_reset result_ok", 64'(result_ok), 64'd0);
        check("async_reset result", result, 64'd0);
        @(negedge clk); resetn = 1'b1;
        run_op(OP_DIVU, 32'd10, 32'd3, "after_reset_10_3");
        check("after_reset const", last_exp, {32'd1, 32'd3});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
